// File: rtl/cluster_assign.sv
// rtl/cluster_assign.sv - nearest-mean pixel classifier over K RGB means (Manhattan distance).
// Optional macro CLUSTER_COUNT_EN adds per-cluster saturating assignment counters.

module manhattan_dist (
   input  logic        en,
   input  logic [23:0] a,
   input  logic [23:0] b,
   output logic [10:0] d
);
   logic [7:0] dr, dg, db;

   always_comb begin
      dr = (a[23:16] > b[23:16]) ? a[23:16] - b[23:16] : b[23:16] - a[23:16];
      dg = (a[15:8]  > b[15:8])  ? a[15:8]  - b[15:8]  : b[15:8]  - a[15:8];
      db = (a[7:0]   > b[7:0])   ? a[7:0]   - b[7:0]   : b[7:0]   - a[7:0];
      d  = en ? ({3'b000, dr} + {3'b000, dg} + {3'b000, db}) : 11'd0;
   end
endmodule

module cluster_assign #(
   parameter int K = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mean_we,
   input  logic [2:0]  mean_addr,
   input  logic [23:0] mean_data,
   input  logic        pixel_valid,
   output logic        pixel_ready,
   input  logic [23:0] pixel,
   output logic        result_valid,
   input  logic        result_ready,
   output logic [2:0]  cluster,
   output logic [10:0] min_d,
   output logic        busy
`ifdef CLUSTER_COUNT_EN
   ,
   input  logic [2:0]  count_sel,
   output logic [15:0] count
`endif
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [3:0] K_LIM    = 4'(K);
   localparam logic [2:0] LAST_IDX = 3'(K - 1);

   state_t      state, state_nx;
   logic [23:0] means [8];
   logic [23:0] pix;
   logic [2:0]  idx;
   logic [10:0] best_d;
   logic [2:0]  best_idx;
   logic [10:0] d;
   logic        dist_en;
   logic        accept;
   logic        take;
   logic        last;
   logic        better;

   manhattan_dist u_dist (
      .en (dist_en),
      .a  (pix),
      .b  (means[idx]),
      .d  (d)
   );

   assign pixel_ready  = (state == IDLE);
   assign result_valid = (state == DONE);
   assign busy         = (state != IDLE);
   assign accept       = pixel_valid && (state == IDLE);
   assign take         = result_ready && (state == DONE);
   assign last         = (idx == LAST_IDX);
   // Strict compare keeps the earliest index on ties; index 0 always seeds the best.
   assign better       = (idx == 3'd0) || (d < best_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      dist_en  = 1'b0;
      case (state)
         IDLE: if (accept) state_nx = SCAN;
         SCAN: begin
            dist_en = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: if (take) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) means[i] <= '0;
         pix      <= '0;
         idx      <= '0;
         best_d   <= '0;
         best_idx <= '0;
         cluster  <= '0;
         min_d    <= '0;
      end else begin
         if (mean_we && (state == IDLE) && ({1'b0, mean_addr} < K_LIM))
            means[mean_addr] <= mean_data;
         if (accept) begin
            pix <= pixel;
            idx <= '0;
         end
         if (state == SCAN) begin
            idx <= idx + 3'd1;
            if (better) begin
               best_d   <= d;
               best_idx <= idx;
            end
            // Outputs update only on the final compare so they hold steady during a scan.
            if (last) begin
               cluster <= better ? idx : best_idx;
               min_d   <= better ? d : best_d;
            end
         end
      end
   end

`ifdef CLUSTER_COUNT_EN
   logic [15:0] counts [8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) counts[i] <= '0;
      end else if (take && (counts[cluster] != 16'hFFFF)) begin
         counts[cluster] <= counts[cluster] + 16'd1;
      end
   end

   assign count = counts[count_sel];
`endif
endmodule
